// File: rtl/opassign_accum_bank.sv
// opassign_accum_bank
//   Bank of NCHAN independent W-bit accumulators. Each one is updated with
//   compound-assignment semantics (=, &=, |=, ^=, +=, -=, <<=, >>=, >>>=) or
//   read. Commands come in on a valid/ready stream. The result (the new
//   accumulator value) and the prior value leave on a registered stream
//   with 1-cycle latency and full throughput.
//
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid/in_ready   command handshake; in_ready = !out_valid || out_ready
//     in_chan             target accumulator
//     in_op               0 = 1 &= 2 |= 3 ^= 4 += 5 -= 6 <<= 7 >>= 8 >>>= 9 read
//     in_operand          right-hand side (OW bits)
//     out_valid/out_ready result handshake
//     out_chan            channel of the result
//     out_result          value of the assignment expression
//     out_old             accumulator value before the command
//     out_err             illegal op (>=10) or channel (>=NCHAN)
//     out_sat             (OPASSIGN_ACCUM_SAT_EN only) += / -= clamped
//
//   Optional macro OPASSIGN_ACCUM_SAT_EN: += and -= saturate instead of wrap.
module opassign_accum_bank #(
   parameter int W      = 8,
   parameter int OW     = 8,
   parameter int NCHAN  = 4,
   parameter int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   parameter bit SIGNED = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_chan,
   input  logic [3:0]    in_op,
   input  logic [OW-1:0] in_operand,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_chan,
   output logic [W-1:0]  out_result,
   output logic [W-1:0]  out_old,
   output logic          out_err
`ifdef OPASSIGN_ACCUM_SAT_EN
   ,
   output logic          out_sat
`endif
);

   localparam logic [3:0] OP_SET  = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_ASR  = 4'd8;
   localparam logic [3:0] OP_READ = 4'd9;

   logic [W-1:0]  acc_q [NCHAN];
   logic [W-1:0]  acc_d [NCHAN];
   logic          out_valid_q, out_valid_d;
   logic [CW-1:0] out_chan_q, out_chan_d;
   logic [W-1:0]  out_result_q, out_result_d;
   logic [W-1:0]  out_old_q, out_old_d;
   logic          out_err_q, out_err_d;

   logic [W-1:0]  opx;
   logic [W-1:0]  cur;
   logic [W-1:0]  new_val;
   logic          chan_ok;
   logic          op_ok;
   logic          accept;

`ifdef OPASSIGN_ACCUM_SAT_EN
   localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   logic          out_sat_q, out_sat_d;
   logic          sat_hit;
   logic [W:0]    sum_x, dif_x;
`endif

   // Operand extension to accumulator width. Shifts use the raw operand.
   generate
      if (OW >= W) begin : g_trunc
         assign opx = in_operand[W-1:0];
      end else if (SIGNED) begin : g_sext
         assign opx = {{(W-OW){in_operand[OW-1]}}, in_operand};
      end else begin : g_zext
         assign opx = {{(W-OW){1'b0}}, in_operand};
      end
   endgenerate

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign op_ok    = (in_op <= OP_READ);

   // Channel select doubles as the range check, so codes >= NCHAN read as 0.
   always_comb begin
      cur     = '0;
      chan_ok = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (in_chan == CW'(i)) begin
            cur     = acc_q[i];
            chan_ok = 1'b1;
         end
      end
   end

   always_comb begin
      new_val = cur;
`ifdef OPASSIGN_ACCUM_SAT_EN
      sat_hit = 1'b0;
      sum_x   = {1'b0, cur} + {1'b0, opx};
      dif_x   = {1'b0, cur} - {1'b0, opx};
`endif
      case (in_op)
         OP_SET: new_val = opx;
         OP_AND: new_val = cur & opx;
         OP_OR:  new_val = cur | opx;
         OP_XOR: new_val = cur ^ opx;
`ifdef OPASSIGN_ACCUM_SAT_EN
         // Signed overflow: result sign differs from cur where the operand
         // signs make overflow possible; clamp toward cur's sign.
         OP_ADD: begin
            new_val = sum_x[W-1:0];
            if (SIGNED) begin
               if ((cur[W-1] == opx[W-1]) && (sum_x[W-1] != cur[W-1])) begin
                  sat_hit = 1'b1;
                  new_val = cur[W-1] ? ~SMAX : SMAX;
               end
            end else if (sum_x[W]) begin
               sat_hit = 1'b1;
               new_val = '1;
            end
         end
         OP_SUB: begin
            new_val = dif_x[W-1:0];
            if (SIGNED) begin
               if ((cur[W-1] != opx[W-1]) && (dif_x[W-1] != cur[W-1])) begin
                  sat_hit = 1'b1;
                  new_val = cur[W-1] ? ~SMAX : SMAX;
               end
            end else if (dif_x[W]) begin
               sat_hit = 1'b1;
               new_val = '0;
            end
         end
`else
         OP_ADD: new_val = cur + opx;
         OP_SUB: new_val = cur - opx;
`endif
         OP_SHL: new_val = cur << in_operand;
         OP_SHR: new_val = cur >> in_operand;
         // Kept as an if so the signed shift is not pulled unsigned by context.
         OP_ASR: begin
            if (SIGNED) new_val = $signed(cur) >>> in_operand;
            else        new_val = cur >> in_operand;
         end
         default: new_val = cur;
      endcase
   end

   always_comb begin
      acc_d        = acc_q;
      out_valid_d  = out_valid_q;
      out_chan_d   = out_chan_q;
      out_result_d = out_result_q;
      out_old_d    = out_old_q;
      out_err_d    = out_err_q;
`ifdef OPASSIGN_ACCUM_SAT_EN
      out_sat_d    = out_sat_q;
`endif
      if (accept) begin
         if (op_ok && chan_ok && (in_op != OP_READ)) begin
            for (int i = 0; i < NCHAN; i++)
               if (in_chan == CW'(i)) acc_d[i] = new_val;
         end
         out_valid_d  = 1'b1;
         out_chan_d   = in_chan;
         out_old_d    = cur;
         out_result_d = (op_ok && chan_ok) ? new_val : cur;
         out_err_d    = !(op_ok && chan_ok);
`ifdef OPASSIGN_ACCUM_SAT_EN
         out_sat_d    = sat_hit && op_ok && chan_ok;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCHAN; i++) acc_q[i] <= '0;
         out_valid_q  <= 1'b0;
         out_chan_q   <= '0;
         out_result_q <= '0;
         out_old_q    <= '0;
         out_err_q    <= 1'b0;
`ifdef OPASSIGN_ACCUM_SAT_EN
         out_sat_q    <= 1'b0;
`endif
      end else begin
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_chan_q   <= out_chan_d;
         out_result_q <= out_result_d;
         out_old_q    <= out_old_d;
         out_err_q    <= out_err_d;
`ifdef OPASSIGN_ACCUM_SAT_EN
         out_sat_q    <= out_sat_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_chan   = out_chan_q;
   assign out_result = out_result_q;
   assign out_old    = out_old_q;
   assign out_err    = out_err_q;
`ifdef OPASSIGN_ACCUM_SAT_EN
   assign out_sat    = out_sat_q;
`endif

endmodule
